mant_div_seq: RTL and testbench

Iterative restoring mantissa divider for the IEEE 754 single-precision divide path. It accepts two normalized 24-bit significands (hidden bit included) and generates the quotient one bit per cycle, MSB first. It drives the quotient onto a serial strobe/data pair (`sld`/`sin`) that a left-shifting 26-bit quotient register consumes directly. It also keeps a parallel copy of the quotient and produces a sticky (inexact) flag for the rounding stage.

---
 rtl/mant_div_seq.sv | 138 +++++++++++++
 tb/tb_mant_div_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mant_div_seq.sv
// Iterative restoring significand divider: one quotient bit per cycle, MSB first,
// streamed on sld/sin with a parallel quotient copy, sticky and divide-by-zero flags.
module mant_div_seq #(
  parameter int MW = 24,
  parameter int QW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [MW-1:0] dividend,
  input  logic [MW-1:0] divisor,
  output logic          busy,
  output logic          sld,
  output logic          sin,
  output logic [QW-1:0] q,
  output logic          sticky,
  output logic          dz,
  output logic          done
);

  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [MW:0]   rem_r;
  logic [MW-1:0] dsr_r;
  logic [CW-1:0] cnt_r;
  logic [QW-1:0] q_r;
  logic          sticky_r;
  logic          dz_r;
  logic          busy_r;
  logic          done_r;

  logic [MW+1:0] diff_s;
  logic          borrow_s;
  logic          qbit_s;
  logic [MW:0]   keep_s;
  logic [MW:0]   rem_nxt_s;
  logic          sld_s;
  logic          sin_s;

  // Trial subtraction and next partial remainder; R < 2D keeps the shift lossless.
  always_comb begin
    diff_s    = {1'b0, rem_r} - {2'b00, dsr_r};
    borrow_s  = diff_s[MW+1];
    qbit_s    = ~borrow_s;
    keep_s    = borrow_s ? rem_r : diff_s[MW:0];
    rem_nxt_s = keep_s << 1;
  end

  // Serial strobe/data are decoded from state so reset drops them immediately.
  always_comb begin
    sld_s = 1'b0;
    sin_s = 1'b0;
    if (state_r == ST_RUN) begin
      sld_s = 1'b1;
      sin_s = qbit_s;
    end else begin
      sld_s = 1'b0;
      sin_s = 1'b0;
    end
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rem_r    <= {(MW+1){1'b0}};
      dsr_r    <= {MW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      q_r      <= {QW{1'b0}};
      sticky_r <= 1'b0;
      dz_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            rem_r    <= {1'b0, dividend};
            dsr_r    <= divisor;
            cnt_r    <= {CW{1'b0}};
            q_r      <= {QW{1'b0}};
            sticky_r <= 1'b0;
            busy_r   <= 1'b1;
            if (divisor == {MW{1'b0}}) begin
              dz_r    <= 1'b1;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              dz_r    <= 1'b0;
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_r <= rem_nxt_s;
          q_r   <= {q_r[QW-2:0], qbit_s};
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(QW - 1)) begin
            sticky_r <= (rem_nxt_s != {(MW+1){1'b0}});
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign sld    = sld_s;
  assign sin    = sin_s;
  assign q      = q_r;
  assign sticky = sticky_r;
  assign dz     = dz_r;
  assign done   = done_r;

endmodule

// File: tb/tb_mant_div_seq.sv
// Scoreboard bench for mant_div_seq: directed divisions, reset abort and back-to-back starts.
module tb_mant_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        busy;
  logic        sld;
  logic        sin;
  logic [25:0] q;
  logic        sticky;
  logic        dz;
  logic        done;

  mant_div_seq #(.MW(24), .QW(26)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .sld(sld), .sin(sin), .q(q), .sticky(sticky), .dz(dz), .done(done)
  );

  typedef struct {
    logic [25:0] q;
    logic        sticky;
    logic        dz;
    int          pulses;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          cyc;
  int          mon_pulses;
  logic [25:0] mon_shift;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter; the accept edge is recorded as cyc read just after it.
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: rebuilds the quotient from sld/sin and compares on every done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_pulses = 0;
      mon_shift  = 26'd0;
    end else begin
      if (sld) begin
        mon_shift = {mon_shift[24:0], sin};
        mon_pulses++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("q", 32'(q), 32'(e.q));
          chk("sticky", 32'(sticky), 32'(e.sticky));
          chk("dz", 32'(dz), 32'(e.dz));
          chk("serial_q", 32'(mon_shift), 32'(e.q));
          chk("sld_pulses", 32'(mon_pulses), 32'(e.pulses));
          chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("busy_at_done", 32'(busy), 32'd1);
        end
        mon_pulses = 0;
        mon_shift  = 26'd0;
      end
    end
  end

  task automatic push_exp(input logic [25:0] eq, input logic es, input logic ed, input int acc);
    exp_t e;
    e.q      = eq;
    e.sticky = es;
    e.dz     = ed;
    e.pulses = ed ? 0 : 26;
    // done is seen QW edges after accept (0 for divide-by-zero)
    e.lat    = ed ? 0 : 26;
    e.acc    = acc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [23:0] a, input logic [23:0] b,
                       input logic [25:0] eq, input logic es, input logic ed);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    push_exp(eq, es, ed, cyc);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sld"}, 32'(sld), 32'd0);
    chk({tag, "_sin"}, 32'(sin), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_q"}, 32'(q), 32'd0);
    chk({tag, "_sticky"}, 32'(sticky), 32'd0);
    chk({tag, "_dz"}, 32'(dz), 32'd0);
  endtask

  initial begin
    int acc;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    mon_pulses = 0;
    mon_shift  = 26'd0;
    rst_n      = 1'b0;
    start      = 1'b0;
    dividend   = 24'd0;
    divisor    = 24'd0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    issue(24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0);
    drain();
    issue(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0);
    drain();
    issue(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0);
    drain();
    issue(24'h800000, 24'h000000, 26'h0000000, 1'b0, 1'b1);
    drain();
    issue(24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0);
    drain();
    issue(24'h800000, 24'hFFFFFF, 26'h1000001, 1'b1, 1'b0);
    drain();

    // Reset ten edges into a run: outputs clear at once and no done follows.
    @(negedge clk);
    dividend = 24'h800000;
    divisor  = 24'h800000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    while (cyc < acc + 10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0);
    drain();

    // Mid-run start pulse is ignored; held start gives the next accept 28 edges later.
    issue(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0);
    acc = cyc;
    repeat (5) @(negedge clk);
    dividend = 24'hC00000;
    divisor  = 24'h800000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 20) @(negedge clk);
    start = 1'b1;
    push_exp(26'h3000000, 1'b0, 1'b0, acc + 28);
    while (cyc < acc + 28) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
